// File: rtl/edge_event_monitor_pkg.sv
// Shared types for the edge event monitor: the per-channel edge mode encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package edge_mon_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

endpackage

// File: rtl/edge_event_monitor_if.sv
// Bundle of monitor inputs (samples, modes, clears, read select) and results.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled or presented each cycle.
// Ports: master drives sig_in/mode/sticky_clr/cnt_clr/rd_sel and observes results;
//        slave (the monitor) does the opposite.
interface edge_event_monitor_if
    import edge_mon_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]        sig_in;
    logic [MODE_W*CH-1:0] mode;
    logic [CH-1:0]        sticky_clr;
    logic                 cnt_clr;
    logic [SEL_W-1:0]     rd_sel;
    logic [CH-1:0]        rose;
    logic [CH-1:0]        fell;
    logic [CH-1:0]        evt;
    logic                 any_evt;
    logic [CH-1:0]        sticky;
    logic [CNT_W-1:0]     rd_data;
    logic                 rd_sat;

    modport master (
        output sig_in, mode, sticky_clr, cnt_clr, rd_sel,
        input  rose, fell, evt, any_evt, sticky, rd_data, rd_sat
    );

    modport slave (
        input  sig_in, mode, sticky_clr, cnt_clr, rd_sel,
        output rose, fell, evt, any_evt, sticky, rd_data, rd_sat
    );

endinterface

// File: rtl/edge_event_monitor_chan.sv
// One monitored channel: history, rise/fall/event pulses, sticky flag, saturating counter.
// Latency: pulses, sticky and counter update at the edge that samples the transition.
// Backpressure: none; the first edge after reset only loads history.
// Ports: sig/mode/sticky_clr/cnt_clr in; rose/fell/evt registered out, evt_nxt is the
//        next-state event for the shared any_evt register, cnt/sat expose the counter.
module edge_chan
    import edge_mon_pkg::*;
#(
    parameter int   CNT_W    = 8,
    parameter logic INIT_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    input  edge_mode_e       mode,
    input  logic             sticky_clr,
    input  logic             cnt_clr,
    output logic             rose,
    output logic             fell,
    output logic             evt,
    output logic             evt_nxt,
    output logic             sticky,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic hist;
    logic hist_vld;
    logic rose_n;
    logic fell_n;

    // Gating with hist_vld keeps INIT_VAL from producing an edge on the first sample.
    always_comb begin
        rose_n  = hist_vld & sig & ~hist;
        fell_n  = hist_vld & ~sig & hist;
        evt_nxt = 1'b0;
        case (mode)
            EDGE_RISE: evt_nxt = rose_n;
            EDGE_FALL: evt_nxt = fell_n;
            EDGE_BOTH: evt_nxt = rose_n | fell_n;
            default:   evt_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= INIT_VAL;
            hist_vld <= 1'b0;
            rose     <= 1'b0;
            fell     <= 1'b0;
            evt      <= 1'b0;
            sticky   <= 1'b0;
            cnt      <= '0;
        end else begin
            hist     <= sig;
            hist_vld <= 1'b1;
            rose     <= rose_n;
            fell     <= fell_n;
            evt      <= evt_nxt;
            // A new event outranks a clear landing on the same edge.
            sticky   <= evt_nxt | (sticky & ~sticky_clr);
            // Clear outranks a coincident event; the event is dropped, not deferred.
            if (cnt_clr)
                cnt <= '0;
            else if (evt_nxt && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/edge_event_monitor.sv
// Multi-channel edge detector/event counter with per-channel sticky flags and a counter read mux.
// Latency: one cycle from sampled transition to rose/fell/evt/any_evt; rd_data is combinational.
// Backpressure: none; inputs are sampled every clk edge.
// Ports: clk, rst (async, active-high), bus (slave modport of edge_event_monitor_if).
module edge_event_monitor
    import edge_mon_pkg::*;
#(
    parameter int            CH       = 4,
    parameter int            CNT_W    = 8,
    parameter logic [CH-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    edge_event_monitor_if.slave   bus
);
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0]    rose_v;
    logic [CH-1:0]    fell_v;
    logic [CH-1:0]    evt_v;
    logic [CH-1:0]    evt_nxt_v;
    logic [CH-1:0]    sticky_v;
    logic [CH-1:0]    sat_v;
    logic [CNT_W-1:0] cnt_a [CH];
    logic             any_evt_q;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .CNT_W    (CNT_W),
            .INIT_VAL (INIT_VAL[i])
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .sig        (bus.sig_in[i]),
            .mode       (edge_mode_e'(bus.mode[MODE_W*i +: MODE_W])),
            .sticky_clr (bus.sticky_clr[i]),
            .cnt_clr    (bus.cnt_clr),
            .rose       (rose_v[i]),
            .fell       (fell_v[i]),
            .evt        (evt_v[i]),
            .evt_nxt    (evt_nxt_v[i]),
            .sticky     (sticky_v[i]),
            .cnt        (cnt_a[i]),
            .sat        (sat_v[i])
        );
    end

    // Built from next-state events so it rises in the same cycle as evt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            any_evt_q <= 1'b0;
        else
            any_evt_q <= |evt_nxt_v;
    end

    // Selects beyond the last channel read as zero.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_sat  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                bus.rd_data = cnt_a[i];
                bus.rd_sat  = sat_v[i];
            end
        end
    end

    assign bus.rose    = rose_v;
    assign bus.fell    = fell_v;
    assign bus.evt     = evt_v;
    assign bus.any_evt = any_evt_q;
    assign bus.sticky  = sticky_v;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Scoreboarded bench for edge_event_monitor: a sample-history reference model predicts each edge.
// Latency: expectations are queued at stimulus time and popped two time units after each posedge.
// Backpressure: none; one expectation per non-reset clock edge.
module tb_edge_event_monitor;
    localparam int CH    = 4;
    localparam int CNT_W = 8;
    localparam int SEL_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [CH-1:0] rose;
        logic [CH-1:0] fell;
        logic [CH-1:0] evt;
        logic          any;
        logic [CH-1:0] sticky;
        int            rd_data;
        logic          rd_sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_event_monitor_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

    edge_event_monitor #(.CH(CH), .CNT_W(CNT_W), .INIT_VAL('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    // Reference state: last sampled vector, whether one exists, and event totals.
    bit            have_prev;
    logic [CH-1:0] prev;
    int            cnt [CH];
    logic [CH-1:0] stk;
    logic [2*CH-1:0] cur_mode;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        have_prev = 1'b0;
        prev      = '0;
        stk       = '0;
        for (int i = 0; i < CH; i++) cnt[i] = 0;
        q.delete();
    endtask

    task automatic set_mode(input int ch, input int m);
        cur_mode[2*ch +: 2] = 2'(m);
    endtask

    task automatic cycle(input logic [CH-1:0] s, input logic [CH-1:0] sc,
                         input logic cc, input int sel);
        exp_t e;
        @(negedge clk);
        bus.sig_in     = s;
        bus.mode       = cur_mode;
        bus.sticky_clr = sc;
        bus.cnt_clr    = cc;
        bus.rd_sel     = SEL_W'(sel);
        if (!rst) begin
            e.rose = '0; e.fell = '0; e.evt = '0;
            for (int i = 0; i < CH; i++) begin
                bit up, dn, ev;
                int md;
                md = int'(cur_mode[2*i +: 2]);
                up = have_prev && !prev[i] && s[i];
                dn = have_prev && prev[i] && !s[i];
                ev = (md == 1) ? up : (md == 2) ? dn : (md == 3) ? (up || dn) : 1'b0;
                e.rose[i] = up;
                e.fell[i] = dn;
                e.evt[i]  = ev;
                if (ev) stk[i] = 1'b1;
                else if (sc[i]) stk[i] = 1'b0;
                if (cc) cnt[i] = 0;
                else if (ev && cnt[i] < CMAX) cnt[i] = cnt[i] + 1;
            end
            e.any     = |e.evt;
            e.sticky  = stk;
            e.rd_data = (sel < CH) ? cnt[sel] : 0;
            e.rd_sat  = (sel < CH) && (cnt[sel] == CMAX);
            prev      = s;
            have_prev = 1'b1;
            q.push_back(e);
        end
    endtask

    // Monitor: compare one queued expectation per edge, decoupled from stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rose",    int'(bus.rose),    int'(e.rose));
                chk("fell",    int'(bus.fell),    int'(e.fell));
                chk("evt",     int'(bus.evt),     int'(e.evt));
                chk("any_evt", int'(bus.any_evt), int'(e.any));
                chk("sticky",  int'(bus.sticky),  int'(e.sticky));
                chk("rd_data", int'(bus.rd_data), e.rd_data);
                chk("rd_sat",  int'(bus.rd_sat),  int'(e.rd_sat));
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rose"},    int'(bus.rose),    0);
        chk({tag, "_fell"},    int'(bus.fell),    0);
        chk({tag, "_evt"},     int'(bus.evt),     0);
        chk({tag, "_any"},     int'(bus.any_evt), 0);
        chk({tag, "_sticky"},  int'(bus.sticky),  0);
        chk({tag, "_rd_data"}, int'(bus.rd_data), 0);
        chk({tag, "_rd_sat"},  int'(bus.rd_sat),  0);
    endtask

    initial begin
        logic [CH-1:0] s;
        cur_mode       = '0;
        for (int i = 0; i < CH; i++) set_mode(i, 1);
        bus.sig_in     = 4'b1111;
        bus.mode       = cur_mode;
        bus.sticky_clr = '0;
        bus.cnt_clr    = 1'b0;
        bus.rd_sel     = '0;
        model_reset();

        // Reset state, then release between clocks with all inputs high.
        repeat (2) @(posedge clk);
        #3;
        check_zero("reset");
        rst = 1'b0;
        cycle(4'b1111, '0, 1'b0, 0);
        cycle(4'b1111, '0, 1'b0, 0);

        // Channel 0 falling edge: one-cycle fell/evt pulse, sticky and count of one.
        set_mode(0, 2);
        cycle(4'b1110, '0, 1'b0, 0);
        cycle(4'b1110, '0, 1'b0, 0);
        cycle(4'b1110, '0, 1'b0, 0);

        // Channel 1 toggles every cycle in both-edge mode until the counter saturates.
        set_mode(1, 3);
        s = 4'b1110;
        for (int k = 0; k < 300; k++) begin
            s[1] = ~s[1];
            cycle(s, '0, 1'b0, 1);
        end
        chk("ch1_saturated_data", int'(bus.rd_data), CMAX);
        chk("ch1_saturated_flag", int'(bus.rd_sat), 1);

        // Channel 2: sticky clear collides with an event, then counter clear collides with one.
        set_mode(2, 1);
        s[2] = 1'b0;
        cycle(s, 4'b0100, 1'b0, 2);
        s[2] = 1'b1;
        cycle(s, 4'b0100, 1'b0, 2);
        cycle(s, 4'b0100, 1'b0, 2);
        s[2] = 1'b0;
        cycle(s, '0, 1'b0, 2);
        s[2] = 1'b1;
        cycle(s, '0, 1'b1, 2);
        cycle(s, '0, 1'b0, 2);

        // Random traffic with channel 3 disabled.
        set_mode(3, 0);
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 3; i++) set_mode(i, int'($urandom_range(0, 3)));
            cycle(4'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000,
                  ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)));
        end

        // Reset asserted between clocks: outputs clear immediately, then fresh random run.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < CH; i++) set_mode(i, int'($urandom_range(0, 3)));
            cycle(4'($urandom), '0, 1'b0, int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
